// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types and default sizes
package stopwatch_pkg;

  // Lap buffer browse state
  typedef enum logic {
    LAP_IDLE,
    LAP_BROWSE
  } lap_state_t;

  localparam int LAP_DEPTH  = 8;
  localparam int TIME_WIDTH = 16;

endpackage

// File: rtl/lap_ram.sv
// rtl/lap_ram.sv - lap storage register file, sync write, async read
module lap_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; the array is deliberately not reset, the controller hides stale slots
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_memory_ctrl.sv
// rtl/lap_memory_ctrl.sv - circular lap buffer controller with newest-first browsing
module lap_memory_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = LAP_DEPTH,
  parameter int WIDTH = TIME_WIDTH
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     write,
  input  logic                     read,
  input  logic [WIDTH-1:0]         time_in,
  output logic [WIDTH-1:0]         lap_out,
  output logic [$clog2(DEPTH)-1:0] lap_index,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  lap_state_t       state, state_next;
  logic [AW-1:0]    wp, wp_next;
  logic [AW:0]      count_next;
  logic [AW-1:0]    idx_next;
  logic             we;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] lap_out_next;

  lap_ram #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wp),
    .wdata(time_in),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Next state: clear beats write beats read; any write cancels browsing
  always_comb begin
    state_next = state;
    wp_next    = wp;
    count_next = count;
    idx_next   = lap_index;
    we         = 1'b0;
    if (clear) begin
      state_next = LAP_IDLE;
      wp_next    = '0;
      count_next = '0;
      idx_next   = '0;
    end else if (write) begin
      we         = 1'b1;
      wp_next    = wp + AW'(1);
      count_next = (count == FULL_COUNT) ? count : count + (AW+1)'(1);
      state_next = LAP_IDLE;
      idx_next   = '0;
    end else if (read) begin
      if (state == LAP_IDLE) begin
        if (count != '0) begin
          state_next = LAP_BROWSE;
          idx_next   = '0;
        end
      end else if ({1'b0, lap_index} == count - (AW+1)'(1)) begin
        idx_next = '0;
      end else begin
        idx_next = lap_index + AW'(1);
      end
    end
  end

  // Look up the lap the cursor will point at after this edge; idle shows zero
  always_comb begin
    raddr        = wp - AW'(1) - idx_next;
    lap_out_next = (state_next == LAP_BROWSE) ? rdata : '0;
  end

  // Pointer, count, FSM and presented-lap registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= LAP_IDLE;
      wp        <= '0;
      count     <= '0;
      lap_index <= '0;
      lap_out   <= '0;
    end else begin
      state     <= state_next;
      wp        <= wp_next;
      count     <= count_next;
      lap_index <= idx_next;
      lap_out   <= lap_out_next;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign valid = (state == LAP_BROWSE);

endmodule
